// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding and the
// default parameter values used by the interface, arbiter and top level.
package adder_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADD_LATENCY = 2;

endpackage

// File: rtl/adder_arbiter_if.sv
// Bus bundle between the requesters / external shared adder and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
);
  localparam int ID_W = $clog2(NUM_REQ);

  // requester side
  logic [NUM_REQ-1:0]            iv_req_valid;
  logic [NUM_REQ-1:0]            ov_req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] iv_req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] iv_req_b;
  logic [NUM_REQ-1:0]            iv_req_cin;
  logic                          i_drain;

  // shared adder side
  logic [DATA_WIDTH-1:0]         ov_add_a;
  logic [DATA_WIDTH-1:0]         ov_add_b;
  logic                          o_add_cin;
  logic                          o_add_en;
  logic [DATA_WIDTH-1:0]         iv_add_sum;
  logic                          i_add_cout;

  // response side
  logic [NUM_REQ-1:0]            ov_rsp_valid;
  logic [DATA_WIDTH-1:0]         ov_rsp_sum;
  logic                          o_rsp_cout;
  logic [ID_W-1:0]               ov_rsp_id;
  logic                          o_idle;

  modport slave (
    input  iv_req_valid, iv_req_a, iv_req_b, iv_req_cin, i_drain,
    input  iv_add_sum, i_add_cout,
    output ov_req_ready, ov_add_a, ov_add_b, o_add_cin, o_add_en,
    output ov_rsp_valid, ov_rsp_sum, o_rsp_cout, ov_rsp_id, o_idle
  );

  modport master (
    output iv_req_valid, iv_req_a, iv_req_b, iv_req_cin, i_drain,
    output iv_add_sum, i_add_cout,
    input  ov_req_ready, ov_add_a, ov_add_b, o_add_cin, o_add_en,
    input  ov_rsp_valid, ov_rsp_sum, o_rsp_cout, ov_rsp_id, o_idle
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from the
// pointer; the pointer moves to one past the winner only when a grant is made.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         iv_req,
  input  logic                       i_en,
  output logic [NUM_REQ-1:0]         ov_grant,
  output logic [$clog2(NUM_REQ)-1:0] ov_grant_id
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] cand;
  logic            found;

  // Index arithmetic modulo NUM_REQ, valid for non-power-of-two counts.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Pick the first requester at or after the pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    ov_grant    = '0;
    ov_grant_id = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_add(ptr_q, i);
      if (i_en && !found && iv_req[cand]) begin
        ov_grant[cand] = 1'b1;
        ov_grant_id    = cand;
        found          = 1'b1;
      end
    end
  end

  // Advance the pointer past the winner; hold it when nobody is granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n)      ptr_q <= '0;
    else if (|ov_grant) ptr_q <= wrap_add(ov_grant_id, 1);
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external pipelined adder between NUM_REQ requesters. Grants are
// round-robin, operands are registered toward the adder, and a tag pipeline
// of depth ADD_LATENCY+1 routes each result back to its requester in order.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADD_LATENCY = DEF_ADD_LATENCY
) (
  input logic             i_clk,
  input logic             i_rst_n,
  adder_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_en;
  logic                  issue;

  logic [DATA_WIDTH-1:0] req_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_b [NUM_REQ];

  logic [DATA_WIDTH-1:0] add_a_q, add_b_q;
  logic                  add_cin_q, add_en_q;

  logic [ADD_LATENCY:0]  tag_v;
  logic [ID_W-1:0]       tag_id [ADD_LATENCY+1];

  logic [NUM_REQ-1:0]    rsp_valid;

  // Unpack the flat operand buses into per-requester words.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign req_a[r] = bus.iv_req_a[r*DATA_WIDTH +: DATA_WIDTH];
    assign req_b[r] = bus.iv_req_b[r*DATA_WIDTH +: DATA_WIDTH];
  end

  // Grants only in RUN with drain low; gating with reset keeps ready low
  // while reset is held even though the grant path is combinational.
  assign grant_en = i_rst_n && (state_q == RUN) && !bus.i_drain;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .iv_req      (bus.iv_req_valid),
    .i_en        (grant_en),
    .ov_grant    (grant),
    .ov_grant_id (grant_id)
  );

  // Ready is only ever raised for a valid requester, so ready alone marks
  // the handshake.
  assign bus.ov_req_ready = grant;
  assign issue            = |grant;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  // FSM next state: drain level directly selects the mode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.i_drain)  state_d = DRAIN;
      DRAIN:   if (!bus.i_drain) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Capture the winner's operands on the grant edge; hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      add_en_q  <= 1'b0;
    end else begin
      add_en_q <= 1'b1;
      if (issue) begin
        add_a_q   <= req_a[grant_id];
        add_b_q   <= req_b[grant_id];
        add_cin_q <= bus.iv_req_cin[grant_id];
      end
    end
  end

  assign bus.ov_add_a  = add_a_q;
  assign bus.ov_add_b  = add_b_q;
  assign bus.o_add_cin = add_cin_q;
  assign bus.o_add_en  = add_en_q;

  // Tag pipeline: stage k holds the op issued k+1 cycles ago, so the last
  // stage lines up with the adder output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the tag storage is reset as a whole; clearing the valid bits
      // is what drops in-flight operations, the ids are cleared for a
      // deterministic state after reset.
      tag_v <= '0;
      for (int i = 0; i <= ADD_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= grant_id;
      for (int i = 1; i <= ADD_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // One-hot result strobe for the requester at the end of the tag pipe.
  always_comb begin
    rsp_valid = '0;
    if (tag_v[ADD_LATENCY]) rsp_valid[tag_id[ADD_LATENCY]] = 1'b1;
  end

  assign bus.ov_rsp_valid = rsp_valid;
  assign bus.ov_rsp_sum   = bus.iv_add_sum;
  assign bus.o_rsp_cout   = bus.i_add_cout;
  assign bus.ov_rsp_id    = tag_id[ADD_LATENCY];
  assign bus.o_idle       = (state_q == DRAIN) && (tag_v == '0);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter with a 2-cycle registered adder model behind it.
// Directed vector table plus hand-written drain / reset sequences; a monitor
// scoreboards every response against {cout,sum} = A+B+cin.
module tb_adder_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int AL = 2;

  logic tb_clk = 1'b0;
  logic tb_rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 tb_clk = ~tb_clk;

  adder_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ADD_LATENCY(AL)) dut (
    .i_clk   (tb_clk),
    .i_rst_n (tb_rst_n),
    .bus     (bus.slave)
  );

  // External shared adder: two register stages from operands to result.
  logic [DW:0] add_s1, add_s2;
  always_ff @(posedge tb_clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      add_s1 <= '0;
      add_s2 <= '0;
    end else begin
      add_s1 <= {1'b0, bus.ov_add_a} + {1'b0, bus.ov_add_b} + (DW+1)'(bus.o_add_cin);
      add_s2 <= add_s1;
    end
  end
  assign bus.iv_add_sum = add_s2[DW-1:0];
  assign bus.i_add_cout = add_s2[DW];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset();
    tb_rst_n         = 1'b0;
    bus.iv_req_valid = '0;
    bus.i_drain      = 1'b0;
    step();
    step();
    tb_rst_n = 1'b1;
  endtask

  // Scoreboard: expected responses in grant order.
  typedef struct {
    logic [1:0]  id;
    logic [15:0] sum;
    logic        cout;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge tb_clk) cyc <= cyc + 1;

  always @(negedge tb_clk) begin : monitor
    exp_t        e;
    logic [16:0] full;
    int          gid;
    if (!tb_rst_n) begin
      exp_q.delete();
    end else begin
      check("ready_legal",
            32'(($countones(bus.ov_req_ready) <= 1) &&
                ((bus.ov_req_ready & ~bus.iv_req_valid) == '0)), 32'd1);
      if (|bus.ov_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(bus.ov_rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_onehot", 32'(bus.ov_rsp_valid), 32'd1 << e.id);
          check("rsp_id",     32'(bus.ov_rsp_id),    32'(e.id));
          check("rsp_sum",    32'(bus.ov_rsp_sum),   32'(e.sum));
          check("rsp_cout",   32'(bus.o_rsp_cout),   32'(e.cout));
          check("rsp_latency", 32'(cyc - e.cyc),     32'(AL + 1));
        end
      end
      if (|bus.ov_req_ready) begin
        gid = 0;
        for (int r = 0; r < NR; r++) if (bus.ov_req_ready[r]) gid = r;
        full = {1'b0, bus.iv_req_a[gid*DW +: DW]} + {1'b0, bus.iv_req_b[gid*DW +: DW]}
             + 17'(bus.iv_req_cin[gid]);
        e.id   = 2'(gid);
        e.sum  = full[15:0];
        e.cout = full[16];
        e.cyc  = cyc;
        exp_q.push_back(e);
      end
    end
  end

  typedef struct {
    int          req;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{2, 16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0};
    vecs[1] = '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{3, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{3, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};

    bus.iv_req_valid = '0;
    bus.iv_req_a     = '0;
    bus.iv_req_b     = '0;
    bus.iv_req_cin   = '0;
    bus.i_drain      = 1'b0;

    // Reset state.
    step();
    step();
    check("rst_ready",   32'(bus.ov_req_ready), 32'd0);
    check("rst_rsp",     32'(bus.ov_rsp_valid), 32'd0);
    check("rst_idle",    32'(bus.o_idle),       32'd0);
    check("rst_add_a",   32'(bus.ov_add_a),     32'd0);
    check("rst_add_en",  32'(bus.o_add_en),     32'd0);
    tb_rst_n = 1'b1;
    step();
    check("add_en_run",  32'(bus.o_add_en),     32'd1);

    // Single-requester vectors with hand-computed results.
    foreach (vecs[i]) begin
      bus.iv_req_valid               = '0;
      bus.iv_req_valid[vecs[i].req]  = 1'b1;
      bus.iv_req_a[vecs[i].req*DW +: DW] = vecs[i].a;
      bus.iv_req_b[vecs[i].req*DW +: DW] = vecs[i].b;
      bus.iv_req_cin[vecs[i].req]    = vecs[i].cin;
      @(negedge tb_clk);
      check("vec_ready", 32'(bus.ov_req_ready), 32'd1 << vecs[i].req);
      step();
      bus.iv_req_valid = '0;
      step();
      step();
      @(negedge tb_clk);
      check("vec_rsp_valid", 32'(bus.ov_rsp_valid), 32'd1 << vecs[i].req);
      check("vec_rsp_sum",   32'(bus.ov_rsp_sum),   32'(vecs[i].exp_sum));
      check("vec_rsp_cout",  32'(bus.o_rsp_cout),   32'(vecs[i].exp_cout));
      check("vec_rsp_id",    32'(bus.ov_rsp_id),    32'(vecs[i].req));
      step();
    end

    // All four requesting continuously from reset: 0,1,2,3,0,...
    for (int r = 0; r < NR; r++) begin
      bus.iv_req_a[r*DW +: DW] = 16'(16'h1111 * (r + 1));
      bus.iv_req_b[r*DW +: DW] = 16'(16'hF000 + r);
      bus.iv_req_cin[r]        = 1'(r % 2);
    end
    do_reset();
    bus.iv_req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge tb_clk);
      check("rr_seq", 32'(bus.ov_req_ready), 32'd1 << (k % NR));
      step();
    end
    bus.iv_req_valid = '0;
    repeat (5) step();

    // Drain with three operations in flight.
    do_reset();
    bus.iv_req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge tb_clk);
      check("drain_pre_grant", 32'(bus.ov_req_ready), 32'd1 << k);
      step();
    end
    bus.i_drain = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      @(negedge tb_clk);
      check("drain_no_grant", 32'(bus.ov_req_ready), 32'd0);
      if (k == 5) begin
        check("drain_last_rsp", 32'(bus.ov_rsp_valid), 32'b0100);
        check("drain_idle_busy", 32'(bus.o_idle), 32'd0);
      end
      if (k == 6) check("drain_idle", 32'(bus.o_idle), 32'd1);
      step();
    end
    bus.i_drain = 1'b0;
    step();
    @(negedge tb_clk);
    check("drain_resume_ptr", 32'(bus.ov_req_ready), 32'b1000);
    step();
    bus.iv_req_valid = '0;
    repeat (5) step();

    // Reset with two operations in flight.
    bus.iv_req_valid = '1;
    for (int k = 0; k < 2; k++) begin
      @(negedge tb_clk);
      check("mid_pre_grant", 32'(bus.ov_req_ready), 32'd1 << k);
      step();
    end
    tb_rst_n = 1'b0;
    #1;
    check("mid_rst_ready",  32'(bus.ov_req_ready), 32'd0);
    check("mid_rst_rsp",    32'(bus.ov_rsp_valid), 32'd0);
    check("mid_rst_idle",   32'(bus.o_idle),       32'd0);
    check("mid_rst_add_a",  32'(bus.ov_add_a),     32'd0);
    check("mid_rst_add_b",  32'(bus.ov_add_b),     32'd0);
    check("mid_rst_cin",    32'(bus.o_add_cin),    32'd0);
    check("mid_rst_add_en", 32'(bus.o_add_en),     32'd0);
    bus.iv_req_valid = 4'b1010;
    step();
    step();
    tb_rst_n = 1'b1;
    @(negedge tb_clk);
    check("mid_first_grant", 32'(bus.ov_req_ready), 32'b0010);
    step();
    bus.iv_req_valid = '0;
    repeat (6) step();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
